// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of decode_queue.
// The decode_queue binds to the slave modport; the fetch/issue environment binds to master.
interface decode_queue_if #(
   parameter int FETCH_WIDTH = 2,
   parameter int DEPTH       = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                      flush;
   logic [FETCH_WIDTH-1:0]    in_valid;
   logic [32*FETCH_WIDTH-1:0] in_inst;
   logic [32*FETCH_WIDTH-1:0] in_pc;
   logic                      in_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [31:0]               out_pc;
   logic [3:0]                out_class;
   logic [4:0]                out_rs1;
   logic [4:0]                out_rs2;
   logic [4:0]                out_rd;
   logic [31:0]               out_imm;
   logic [2:0]                out_funct3;
   logic                      out_alt;
   logic [CW-1:0]             count;

   modport master (
      output flush,
      output in_valid,
      output in_inst,
      output in_pc,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_pc,
      input  out_class,
      input  out_rs1,
      input  out_rs2,
      input  out_rd,
      input  out_imm,
      input  out_funct3,
      input  out_alt,
      input  count
   );

   modport slave (
      input  flush,
      input  in_valid,
      input  in_inst,
      input  in_pc,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_pc,
      output out_class,
      output out_rs1,
      output out_rs2,
      output out_rd,
      output out_imm,
      output out_funct3,
      output out_alt,
      output count
   );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode stage: decodes up to FETCH_WIDTH lanes on enqueue into a DEPTH-entry FIFO, issues one per cycle.
// Optional feature macro: DECODE_QUEUE_MULDIV_EN (decode M-extension OP encodings as class MULDIV).
module decode_queue #(
   parameter int FETCH_WIDTH = 2,
   parameter int DEPTH       = 8
) (
   input logic           clk,
   input logic           rst,
   decode_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [3:0] C_OP      = 4'd1;
   localparam logic [3:0] C_OP_IMM  = 4'd2;
   localparam logic [3:0] C_LUI     = 4'd3;
   localparam logic [3:0] C_AUIPC   = 4'd4;
   localparam logic [3:0] C_JAL     = 4'd5;
   localparam logic [3:0] C_JALR    = 4'd6;
   localparam logic [3:0] C_BR      = 4'd7;
   localparam logic [3:0] C_LD      = 4'd8;
   localparam logic [3:0] C_ST      = 4'd9;
   localparam logic [3:0] C_MULDIV  = 4'd10;
   localparam logic [3:0] C_ILLEGAL = 4'd15;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BR     = 7'b1100011;
   localparam logic [6:0] OPC_LD     = 7'b0000011;
   localparam logic [6:0] OPC_ST     = 7'b0100011;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  cls;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [2:0]  funct3;
      logic        alt;
   } entry_t;

   // Anything not explicitly recognised falls through as ILLEGAL with register/immediate fields zeroed.
   function automatic entry_t decode_inst(input logic [31:0] inst, input logic [31:0] pc);
      entry_t     e;
      logic [6:0] opc;
      logic [6:0] f7;
      logic [2:0] f3;
      logic [31:0] imm_i;
      logic [31:0] imm_s;
      logic [31:0] imm_b;
      logic [31:0] imm_u;
      logic [31:0] imm_j;
      opc   = inst[6:0];
      f7    = inst[31:25];
      f3    = inst[14:12];
      imm_i = {{20{inst[31]}}, inst[31:20]};
      imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      imm_u = {inst[31:12], 12'b0};
      imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      e        = '0;
      e.pc     = pc;
      e.funct3 = f3;
      e.cls    = C_ILLEGAL;
      case (opc)
         OPC_OP: begin
            if (f7 == 7'b0000000 ||
                (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
               e.cls = C_OP;
               e.rs1 = inst[19:15];
               e.rs2 = inst[24:20];
               e.rd  = inst[11:7];
               e.alt = inst[30];
            end
`ifdef DECODE_QUEUE_MULDIV_EN
            else if (f7 == 7'b0000001) begin
               e.cls = C_MULDIV;
               e.rs1 = inst[19:15];
               e.rs2 = inst[24:20];
               e.rd  = inst[11:7];
            end
`endif
         end
         OPC_OP_IMM: begin
            if (f3 == 3'b001 || f3 == 3'b101) begin
               if (f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000)) begin
                  e.cls = C_OP_IMM;
                  e.rs1 = inst[19:15];
                  e.rd  = inst[11:7];
                  e.imm = {27'b0, inst[24:20]};
                  e.alt = inst[30];
               end
            end else begin
               e.cls = C_OP_IMM;
               e.rs1 = inst[19:15];
               e.rd  = inst[11:7];
               e.imm = imm_i;
               e.alt = inst[30];
            end
         end
         OPC_LUI: begin
            e.cls = C_LUI;
            e.rd  = inst[11:7];
            e.imm = imm_u;
         end
         OPC_AUIPC: begin
            e.cls = C_AUIPC;
            e.rd  = inst[11:7];
            e.imm = imm_u;
         end
         OPC_JAL: begin
            e.cls = C_JAL;
            e.rd  = inst[11:7];
            e.imm = imm_j;
         end
         OPC_JALR: begin
            e.cls = C_JALR;
            e.rs1 = inst[19:15];
            e.rd  = inst[11:7];
            e.imm = imm_i;
         end
         OPC_BR: begin
            e.cls = C_BR;
            e.rs1 = inst[19:15];
            e.rs2 = inst[24:20];
            e.imm = imm_b;
         end
         OPC_LD: begin
            e.cls = C_LD;
            e.rs1 = inst[19:15];
            e.rd  = inst[11:7];
            e.imm = imm_i;
         end
         OPC_ST: begin
            e.cls = C_ST;
            e.rs1 = inst[19:15];
            e.rs2 = inst[24:20];
            e.imm = imm_s;
         end
         default: begin
            e.cls = C_ILLEGAL;
         end
      endcase
      return e;
   endfunction

   entry_t        r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   entry_t        w_dec    [FETCH_WIDTH];
   logic [PW-1:0] w_wr_idx [FETCH_WIDTH];
   logic [CW-1:0] w_push_cnt;
   logic [CW-1:0] w_count_next;
   logic [CW-1:0] w_space;
   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_push;
   logic          w_pop;
   logic          w_valid_contig;
   entry_t        w_head;

   generate
      for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
         assign w_dec[gi]    = decode_inst(bus.in_inst[32*gi +: 32], bus.in_pc[32*gi +: 32]);
         assign w_wr_idx[gi] = r_wr_ptr + PW'(gi);
      end
   endgenerate

   always_comb begin
      w_push_cnt = '0;
      for (int l = 0; l < FETCH_WIDTH; l++) begin
         w_push_cnt = w_push_cnt + CW'(bus.in_valid[l]);
      end
   end

   // Readiness uses the pre-pop occupancy, so a slot freed this cycle is not reused until the next.
   assign w_space     = CW'(DEPTH) - r_count;
   assign w_in_ready  = (w_space >= CW'(FETCH_WIDTH));
   assign w_out_valid = (r_count != '0);
   assign w_push      = w_in_ready && (|bus.in_valid) && !bus.flush;
   assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

   always_comb begin
      w_count_next = r_count;
      if (w_push) begin
         w_count_next = w_count_next + w_push_cnt;
      end
      if (w_pop) begin
         w_count_next = w_count_next - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_cnt);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (bus.in_valid[l]) begin
               r_mem[w_wr_idx[l]] <= w_dec[l];
            end
         end
      end
   end

   // Outputs come straight from the head slot, forced to zero while the queue is empty.
   assign w_head         = w_out_valid ? r_mem[r_rd_ptr] : '0;
   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_pc     = w_head.pc;
   assign bus.out_class  = w_head.cls;
   assign bus.out_rs1    = w_head.rs1;
   assign bus.out_rs2    = w_head.rs2;
   assign bus.out_rd     = w_head.rd;
   assign bus.out_imm    = w_head.imm;
   assign bus.out_funct3 = w_head.funct3;
   assign bus.out_alt    = w_head.alt;
   assign bus.count      = r_count;

   assign w_valid_contig = ((bus.in_valid + FETCH_WIDTH'(1)) & bus.in_valid) == '0;

`ifndef SYNTHESIS
   a_valid_contig: assert property (@(posedge clk) disable iff (rst) w_valid_contig);
`endif
endmodule
